// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: encoder pins, controls and step/error outputs of quad_step_decoder
interface quad_step_decoder_if #(
    parameter int width_p = 4
);
    logic               a_i;
    logic               b_i;
    logic               enable_i;
    logic               clear_i;
    logic               up_o;
    logic               down_o;
    logic               dir_o;
    logic               err_o;
    logic [width_p-1:0] err_count_o;

    modport master (
        output a_i, b_i, enable_i, clear_i,
        input  up_o, down_o, dir_o, err_o, err_count_o
    );

    modport slave (
        input  a_i, b_i, enable_i, clear_i,
        output up_o, down_o, dir_o, err_o, err_count_o
    );
endinterface

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronized, glitch-filtered quadrature decoder with step strobes and error count; define QUAD_X1_MODE_EN for x1 decoding
module quad_step_decoder #(
    parameter int filter_p = 4,
    parameter int width_p  = 4
) (
    input logic                clk_i,
    input logic                reset_i,
    quad_step_decoder_if.slave bus
);
    localparam int cw = $clog2(filter_p + 1);
    localparam logic [cw-1:0] last_p = cw'(filter_p - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             init_q, init_d;
    logic [1:0]             sync1_q, sync2_q;
    logic [1:0]             filt_q, filt_d;
    logic [1:0][cw-1:0]     cnt_q, cnt_d;
    logic [1:0]             prev_q, prev_d;
    logic                   up_q, up_d, down_q, down_d, err_q, err_d, dir_q, dir_d;
    logic [width_p-1:0]     errcnt_q, errcnt_d;
    logic [1:0]             diff;
    logic                   fwd;

    assign diff = filt_q ^ prev_q;
    // a forward Gray step always lands with the new B equal to the old A
    assign fwd  = ~(prev_q[1] ^ filt_q[0]);

    // next-state: startup loading, per-channel filtering, step decoding and error counting
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        err_d    = 1'b0;
        dir_d    = dir_q;
        errcnt_d = errcnt_q;
        if (state_q == INIT) begin
            filt_d = sync2_q;
            init_d = init_q + 2'd1;
            if (init_q == 2'd2) begin
                state_d = RUN;
                // seed with the value filtered on this same edge so the first RUN cycle sees no step
                prev_d  = sync2_q;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2_q[k] != filt_q[k]) begin
                    if (cnt_q[k] == last_p) begin
                        filt_d[k] = sync2_q[k];
                        cnt_d[k]  = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end else begin
                    cnt_d[k] = '0;
                end
            end
            prev_d = filt_q;
            err_d  = &diff;
            if (^diff) begin
                dir_d  = fwd;
`ifdef QUAD_X1_MODE_EN
                up_d   = bus.enable_i && prev_q == 2'b01 && filt_q == 2'b00;
                down_d = bus.enable_i && prev_q == 2'b00 && filt_q == 2'b01;
`else
                up_d   = bus.enable_i & fwd;
                down_d = bus.enable_i & ~fwd;
`endif
            end
            if (err_d && errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
        end
        if (bus.clear_i) errcnt_d = '0;
    end

    // two-flop pin synchronizers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.a_i, bus.b_i};
            sync2_q <= sync1_q;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= INIT;
            init_q   <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            up_q     <= up_d;
            down_q   <= down_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.up_o        = up_q;
    assign bus.down_o      = down_q;
    assign bus.err_o       = err_q;
    assign bus.dir_o       = dir_q;
    assign bus.err_count_o = errcnt_q;
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed checks of filtering, decoding, errors, enable and reset
module tb_quad_step_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int up_cnt, down_cnt, err_cnt, multi, wide, lat, t0;
    logic lat_arm = 1'b0;
    logic strobe_prev = 1'b0;

    quad_step_decoder_if #(.width_p(4)) bus();

    quad_step_decoder #(.filter_p(4), .width_p(4)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.up_o) up_cnt++;
        if (bus.down_o) down_cnt++;
        if (bus.err_o) err_cnt++;
        if (int'(bus.up_o) + int'(bus.down_o) + int'(bus.err_o) > 1) multi++;
        if ((bus.up_o || bus.down_o) && strobe_prev) wide++;
        strobe_prev = bus.up_o | bus.down_o;
        if (bus.up_o && lat_arm) begin
            lat = cyc - t0;
            lat_arm = 1'b0;
        end
    end

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        up_cnt = 0;
        down_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic step(logic [1:0] ab);
        bus.a_i = ab[1];
        bus.b_i = ab[0];
        tick(10);
    endtask

    initial begin
        int exp_fwd, exp_rev, exp_a4;
`ifdef QUAD_X1_MODE_EN
        exp_fwd = 1;
        exp_rev = 1;
        exp_a4  = 0;
`else
        exp_fwd = 4;
        exp_rev = 4;
        exp_a4  = 1;
`endif
        multi = 0;
        wide = 0;
        lat = -1;
        clr_counts();
        bus.a_i = 1'b1;
        bus.b_i = 1'b1;
        bus.enable_i = 1'b1;
        bus.clear_i = 1'b0;
        tick(3);
        check("reset_up", int'(bus.up_o), 0);
        check("reset_cnt", int'(bus.err_count_o), 0);
        rst = 1'b0;
        tick(20);
        check("idle11_up", up_cnt, 0);
        check("idle11_down", down_cnt, 0);
        check("idle11_err", err_cnt, 0);
        check("idle11_errcnt", int'(bus.err_count_o), 0);
        check("idle11_dir", int'(bus.dir_o), 0);

        rst = 1'b1;
        bus.a_i = 1'b0;
        bus.b_i = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rerun_quiet", up_cnt + down_cnt + err_cnt, 0);

        clr_counts();
        t0 = cyc + 1;
        lat_arm = 1'b1;
        step(2'b10);
        step(2'b11);
        step(2'b01);
        step(2'b00);
        tick(5);
        check("fwd_up", up_cnt, exp_fwd);
        check("fwd_down", down_cnt, 0);
        check("fwd_err", err_cnt, 0);
        check("fwd_dir", int'(bus.dir_o), 1);
`ifndef QUAD_X1_MODE_EN
        check("fwd_latency", lat, 6);
`endif

        clr_counts();
        step(2'b01);
        step(2'b11);
        step(2'b10);
        step(2'b00);
        tick(5);
        check("rev_down", down_cnt, exp_rev);
        check("rev_up", up_cnt, 0);
        check("rev_dir", int'(bus.dir_o), 0);

        clr_counts();
        bus.a_i = 1'b1;
        tick(3);
        bus.a_i = 1'b0;
        tick(12);
        check("glitch3", up_cnt + down_cnt + err_cnt, 0);
        bus.a_i = 1'b1;
        tick(12);
        check("pulse4_up", up_cnt, exp_a4);
        bus.a_i = 1'b0;
        tick(12);
        check("pulse4_back", down_cnt, exp_a4);

        clr_counts();
        for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 2'b11 : 2'b00);
        tick(5);
        check("err_pulses", err_cnt, 20);
        check("err_sat", int'(bus.err_count_o), 15);
        check("err_nostep", up_cnt + down_cnt, 0);
        bus.clear_i = 1'b1;
        tick(1);
        bus.clear_i = 1'b0;
        tick(1);
        check("err_clear", int'(bus.err_count_o), 0);

        clr_counts();
        bus.enable_i = 1'b0;
        step(2'b10);
        step(2'b11);
        step(2'b01);
        check("dis_up", up_cnt + down_cnt, 0);
        check("dis_dir", int'(bus.dir_o), 1);
        bus.enable_i = 1'b1;
        step(2'b00);
        tick(5);
        check("reen_up", up_cnt, 1);
        check("reen_down", down_cnt, 0);

        check("exclusive", multi, 0);
        check("one_cycle", wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature (A/B) step decoder: the driving end of the loadable up/down counter's up/down interface.
- Synchronizes and glitch-filters two asynchronous encoder pins and tracks Gray-code state.
- Emits mutually exclusive single-cycle up/down strobes, wired directly to the counter's up_i/down_i.
- Flags and counts illegal two-bit jumps.

Parameters:
filter_p, 4, consecutive cycles a synchronized pin must differ from its filtered value before the filtered value updates; legal range >= 1
width_p, 4, width of saturating error counter

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous, active-high reset
a_i  input  1  encoder channel A, asynchronous to clk_i
b_i  input  1  encoder channel B, asynchronous to clk_i
enable_i  input  1  strobe enable; state tracking continues when low
clear_i  input  1  synchronous clear of err_count_o
up_o  output  1  one-cycle forward step strobe
down_o  output  1  one-cycle reverse step strobe
dir_o  output  1  direction of last valid step: 1 = forward, 0 = reverse
err_o  output  1  one-cycle illegal-transition strobe
err_count_o  output  width_p  saturating illegal-transition count

Behaviour:
- Reset: async, active-high. While asserted: up_o=0, down_o=0, err_o=0, dir_o=0, err_count_o=0, synchronizers=0, filter counters=0, FSM in INIT.
- Synchronizer: two flops per channel (sync1 -> sync2).
- FSM states:
  - INIT: lasts exactly 3 cycles after reset release. Filtered A/B load sync2 directly every cycle. No strobes. On exit, prev_state <= filtered {A,B}; go to RUN.
  - RUN: normal operation.
- Filter (RUN, per channel):
  - If sync2 != filtered, counter increments; when it reaches filter_p, filtered <= sync2 and counter <= 0.
  - If sync2 == filtered, counter <= 0.
- Decode (RUN): compares filtered {A,B} against prev_state each cycle, then prev_state <= filtered. Outputs are registered.
  - Forward sequence: 00 -> 10 -> 11 -> 01 -> 00. A valid forward transition gives up_o=1 for 1 cycle and dir_o <= 1.
  - Reverse sequence: 00 -> 01 -> 11 -> 10 -> 00. A valid reverse transition gives down_o=1 for 1 cycle and dir_o <= 0.
  - Both bits change in the same cycle (00<->11, 01<->10): err_o=1 for 1 cycle, err_count_o increments, no up/down strobe, dir_o unchanged, prev_state still updates.
  - No change: all strobes 0.
- Latency: a pin change first sampled at rising edge 0 produces a strobe that is high during the cycle following edge filter_p+2.
  - That is filter_p+3 edges total; 7 edges for filter_p=4.
- Exclusivity: up_o, down_o and err_o are never high together. Minimum spacing between strobes is 1 cycle.
- enable_i=0: up_o and down_o are forced 0. dir_o, err_o, err_count_o and prev_state still update, so re-enable never produces a catch-up strobe.
- err_count_o:
  - Saturates at 2^width_p-1.
  - clear_i sets it to 0 next edge.
  - If clear_i and an error coincide, clear wins (result 0).
- Glitches: a pulse shorter than filter_p cycles at sync2 is fully rejected.
- Reset mid-operation: all state is discarded immediately, then INIT re-runs. No strobe appears in the first 3 cycles after release.

Optional Feature:
- Macro: QUAD_X1_MODE_EN.
- Defined: x1 decoding.
  - up_o fires only on the forward transition 01 -> 00.
  - down_o fires only on the reverse transition 00 -> 01.
  - Other valid transitions update prev_state and dir_o silently.
  - Error handling is unchanged.
- Undefined: x4 decoding; every valid transition strobes.

Test Plan:
1. filter_p=4. Reset with a_i=b_i=1 held, release, run 20 cycles -> up_o=down_o=err_o=0, err_count_o=0.
2. Forward sequence 00,10,11,01,00, each held 10 cycles, enable_i=1 -> exactly 4 up_o pulses, each 1 cycle wide, each 7 edges after the pin change; dir_o=1; x1 build: 1 pulse, on the final step.
3. Reverse sequence 00,01,11,10,00 -> 4 down_o pulses, dir_o=0, no up_o.
4. From 00, a_i high for 3 cycles then low -> no strobe. a_i high for 4+ cycles -> exactly 1 up_o.
5. Toggle a_i and b_i together 00->11, repeated 20 times with width_p=4 -> 20 err_o pulses, err_count_o saturates at 15, no up/down. Assert clear_i 1 cycle -> err_count_o=0.
6. enable_i=0 during 3 forward steps -> no up_o, dir_o=1. enable_i=1, one more forward step -> exactly 1 up_o.
